// File: rtl/dp_ram_arb_pkg.sv
// Shared types and helpers for the port-B RAM arbiter and round-robin selectors.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package dp_ram_arb_pkg;

    // RAM wrapper read data appears one cycle after the address is presented.
    localparam int RAM_RD_LATENCY = 1;
    // Widest requester vector the round-robin helper handles.
    localparam int MAX_REQ        = 8;
    // Word address width of the 512x32 RAM wrapper.
    localparam int RAM_AW         = 9;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } ram_req_t;

    // Returns a one-hot pick of the first set req bit at or after ptr,
    // wrapping modulo n. Bits at index n and above are never set.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                idx = int'(ptr) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[2:0]]) begin
                    pick[idx[2:0]] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dp_ram_portb_arbiter_rr_prio_pick.sv
// Round-robin selector: first request at or after ptr, as one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pointer moves.
module rr_prio_pick
    import dp_ram_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [MAX_REQ-1:0] pick;

    // Rotate-from-pointer priority search, then encode the winner.
    always_comb begin
        pick  = rr_pick(MAX_REQ'(req_i), 3'(ptr_i), N);
        gnt_o = pick[N-1:0];
        any_o = |pick;
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dp_ram_portb_arbiter.sv
// Shares RAM port B among NUM_REQ masters: round-robin grant with burst lock, read data routed back by tag.
// Latency: grant same cycle as req; read data/rvalid one cycle after the read grant.
// Backpressure: a requester holds req and its fields until it sees gnt; losers simply wait.
module dp_ram_portb_arbiter
    import dp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  lock_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ-1:0][31:0]            wdata_i,
    input  logic [NUM_REQ-1:0][3:0]             be_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [31:0]                         rdata_o,
    output logic [ADDR_WIDTH-1:0]               ram_addr_o,
    output logic [31:0]                         ram_wdata_o,
    output logic                                ram_we_o,
    output logic [3:0]                          ram_be_o,
    input  logic [31:0]                         ram_rdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [31:0]           ram_wdata_q;

    logic [IDX_W-1:0]      eff_ptr;
    logic                  lock_hold;
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    ram_req_t              sel;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // The lock owner keeps the port only while both its req and lock stay high.
    // On the release cycle the search starts just past the owner, so the owner
    // cannot immediately win again over a waiting requester.
    assign lock_hold = lock_vld_q & req_i[lock_idx_q] & lock_i[lock_idx_q];
    assign eff_ptr   = lock_vld_q ? idx_inc(lock_idx_q) : ptr_q;

    rr_prio_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (eff_ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Grant selection and RAM request mux; idle cycles hold addr/wdata and drop we/be.
    always_comb begin
        gnt_o   = '0;
        gnt_idx = pick_idx;
        gnt_any = 1'b0;
        if (rst) begin
            gnt_any = 1'b0;
        end else if (lock_hold) begin
            gnt_o[lock_idx_q] = 1'b1;
            gnt_idx           = lock_idx_q;
            gnt_any           = 1'b1;
        end else begin
            gnt_o   = pick_gnt;
            gnt_idx = pick_idx;
            gnt_any = pick_any;
        end
        sel.we      = we_i[gnt_idx];
        sel.addr    = RAM_AW'(addr_i[gnt_idx]);
        sel.wdata   = wdata_i[gnt_idx];
        sel.be      = be_i[gnt_idx];
        ram_we_o    = gnt_any & sel.we;
        ram_be_o    = gnt_any ? sel.be : 4'b0000;
        ram_addr_o  = gnt_any ? ADDR_WIDTH'(sel.addr) : ram_addr_q;
        ram_wdata_o = gnt_any ? sel.wdata : ram_wdata_q;
    end

    // Pointer, lock-owner and read-tag next state.
    always_comb begin
        ptr_d      = eff_ptr;
        lock_vld_d = 1'b0;
        lock_idx_d = lock_idx_q;
        rd_vld_d   = gnt_any & ~sel.we;
        rd_idx_d   = gnt_idx;
        if (gnt_any) begin
            if (lock_i[gnt_idx]) begin
                lock_vld_d = 1'b1;
                lock_idx_d = gnt_idx;
                ptr_d      = ptr_q;
            end else begin
                ptr_d = idx_inc(gnt_idx);
            end
        end
    end

    // Read return: the tag from the grant cycle qualifies the RAM output one cycle later.
    always_comb begin
        rvalid_o = '0;
        if (rd_vld_q) begin
            rvalid_o[rd_idx_q] = 1'b1;
        end
    end

    assign rdata_o = ram_rdata_i;

    // State registers; reset drops any in-flight read tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            lock_vld_q  <= 1'b0;
            lock_idx_q  <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_idx_q  <= lock_idx_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            ram_addr_q  <= ram_addr_o;
            ram_wdata_q <= ram_wdata_o;
        end
    end

endmodule
